// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, redirect flush, memory-wait hold, registered forwarding selects and hazard counters.
module hazard_unit #(
  parameter int CNT_W = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             stall,
  output logic             branch,
  output logic             hold,
  output logic             forward,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, load_use;
  logic [1:0] sel_a, sel_b;
  function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd, input logic use_rs, input logic rw_n);
    return use_rs && rs == rd && rd != 5'd0 && !rw_n;
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic e);
    return (e && !(&c)) ? c + 1'b1 : c;
  endfunction
  // WB matches are resolved by regfile write-before-read, so they select the regfile
  always_comb begin
    ex_a = hit(id_rs1, ex_rd, id_use_rs1, ex_reg_write);
    ex_b = hit(id_rs2, ex_rd, id_use_rs2, ex_reg_write);
    mem_a = hit(id_rs1, mem_rd, id_use_rs1, mem_reg_write);
    mem_b = hit(id_rs2, mem_rd, id_use_rs2, mem_reg_write);
    wb_a = hit(id_rs1, wb_rd, id_use_rs1, wb_reg_write);
    wb_b = hit(id_rs2, wb_rd, id_use_rs2, wb_reg_write);
    load_use = ex_mem_read && (ex_a || ex_b);
    sel_a = (ex_a && !ex_mem_read) ? 2'b01 : mem_a ? 2'b10 : wb_a ? 2'b00 : 2'b00;
    sel_b = (ex_b && !ex_mem_read) ? 2'b01 : mem_b ? 2'b10 : wb_b ? 2'b00 : 2'b00;
    hold = (state == MEM_WAIT) ? !dmem_ready : dmem_req && !dmem_ready;
    branch = !hold && ex_redirect;
    stall = !hold && !ex_redirect && load_use;
    ifid_flush = branch;
    pc_write = !hold && !stall;
    ifid_write = pc_write;
    state_nx = hold ? MEM_WAIT : RUN;
  end
  assign forward = (|fwd_a) || (|fwd_b);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
      hold_cnt <= '0;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (!hold) begin
        fwd_a <= (stall || branch) ? 2'b00 : sel_a;
        fwd_b <= (stall || branch) ? 2'b00 : sel_b;
      end
      stall_cnt <= sat(stall_cnt, stall);
      flush_cnt <= sat(flush_cnt, branch);
      hold_cnt <= sat(hold_cnt, hold);
      wait_cnt <= (state == MEM_WAIT) ? sat(wait_cnt, 1'b1) : '0;
      mem_timeout <= mem_timeout || (state == MEM_WAIT && wait_cnt >= WAIT_LAST);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors, expected outputs queued per cycle and checked by a negedge monitor.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic ex_mem_read, ex_redirect, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, stall, branch, hold, forward, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt, hold_cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string name;
    logic [5:0] ctl;
    logic [4:0] fw;
    logic to;
    logic [11:0] cnt;
  } exp_t;
  exp_t q[$];
  localparam logic [5:0] NRM = 6'b110000, STL = 6'b000100, BRN = 6'b111010, HLD = 6'b000001;
  hazard_unit #(.CNT_W(4), .WAIT_MAX(3)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .stall(stall),
    .branch(branch), .hold(hold), .forward(forward), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "ctl", 12'({pc_write, ifid_write, ifid_flush, stall, branch, hold}), 12'(e.ctl));
      chk(e.name, "fwd", 12'({forward, fwd_a, fwd_b}), 12'(e.fw));
      chk(e.name, "timeout", 12'(mem_timeout), 12'(e.to));
      chk(e.name, "cnt", {stall_cnt, flush_cnt, hold_cnt}, e.cnt);
    end
  end
  task automatic idle();
    {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ready} = '0;
    {ex_reg_write, mem_reg_write, wb_reg_write} = 3'b111;
  endtask
  task automatic step(input string n, input logic [5:0] c, input logic [4:0] f, input logic t,
                      input int sc, input int fc, input int hc);
    exp_t e;
    e.name = n;
    e.ctl = c;
    e.fw = f;
    e.to = t;
    e.cnt = {4'(sc), 4'(fc), 4'(hc)};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic load_use();
    idle();
    ex_rd = 5; ex_reg_write = 0; ex_mem_read = 1; id_rs1 = 5; id_use_rs1 = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; idle();
    @(posedge clk); #1;
    step("rst", NRM, 0, 0, 0, 0, 0);
    reset = 0;
    load_use();
    step("lu_stall", STL, 0, 0, 0, 0, 0);
    ex_rd = 0; ex_reg_write = 1; ex_mem_read = 0; mem_rd = 5; mem_reg_write = 0;
    step("lu_bubble", NRM, 0, 0, 1, 0, 0);
    idle();
    step("lu_fwd", NRM, 5'b11000, 0, 1, 0, 0);
    ex_rd = 3; ex_reg_write = 0; mem_rd = 3; mem_reg_write = 0; id_rs2 = 3; id_use_rs2 = 1;
    step("alu_issue", NRM, 0, 0, 1, 0, 0);
    ex_rd = 0; mem_rd = 0;
    step("alu_fwd_ex", NRM, 5'b10001, 0, 1, 0, 0);
    ex_rd = 7; mem_rd = 3;
    step("rd0_fwd", NRM, 0, 0, 1, 0, 0);
    idle(); wb_rd = 3; wb_reg_write = 0; id_rs2 = 3; id_use_rs2 = 1;
    step("mem_fwd", NRM, 5'b10010, 0, 1, 0, 0);
    idle();
    step("wb_nofwd", NRM, 0, 0, 1, 0, 0);
    load_use(); ex_redirect = 1;
    step("redir_lu", BRN, 0, 0, 1, 0, 0);
    idle(); ex_rd = 3; ex_reg_write = 0; id_rs2 = 3; id_use_rs2 = 1;
    step("after_redir", NRM, 0, 0, 1, 1, 0);
    idle(); mem_rd = 3; mem_reg_write = 0; id_rs2 = 3; id_use_rs2 = 1; dmem_req = 1; ex_redirect = 1;
    step("hold_redir", HLD, 5'b10001, 0, 1, 1, 0);
    ex_redirect = 0;
    step("hold1", HLD, 5'b10001, 0, 1, 1, 1);
    step("hold2", HLD, 5'b10001, 0, 1, 1, 2);
    step("hold3", HLD, 5'b10001, 0, 1, 1, 3);
    idle(); dmem_req = 1; dmem_ready = 1;
    step("wait_exit", NRM, 5'b10001, 1, 1, 1, 4);
    step("ready_now", NRM, 0, 1, 1, 1, 4);
    idle();
    step("no_wait", NRM, 0, 1, 1, 1, 4);
    dmem_req = 1;
    step("hold_again", HLD, 0, 1, 1, 1, 4);
    idle(); reset = 1;
    step("rst_mid_wait", HLD, 0, 1, 1, 1, 5);
    step("rst_held", NRM, 0, 0, 0, 0, 0);
    reset = 0;
    step("wait_aborted", NRM, 0, 0, 0, 0, 0);
    load_use();
    for (int i = 0; i < 20; i++) step("sat", STL, 0, 0, (i > 15) ? 15 : i, 0, 0);
    idle();
    step("sat_end", NRM, 0, 0, 15, 0, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
